// File: rtl/unique0_dr.sv
// JTAG data-register bank: captures, shifts and updates the DR selected by the
// decoded instruction, and drives the IC reset selects and AXI request descriptor.

package jtag_pkg;

   localparam int ADDR_AXI_WIDTH = 32;
   localparam int DATA_AXI_WIDTH = 32;
   localparam int DR_MAX_WIDTH   = 32;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET,
      RUN_TEST_IDLE,
      SELECT_DR,
      CAPTURE_DR,
      SHIFT_DR,
      EXIT1_DR,
      PAUSE_DR,
      EXIT2_DR,
      UPDATE_DR,
      SELECT_IR,
      CAPTURE_IR,
      SHIFT_IR,
      EXIT1_IR,
      PAUSE_IR,
      EXIT2_IR,
      UPDATE_IR
   } tap_ctrl_fsm_t;

   typedef enum logic [2:0] {
      BYPASS,
      IDCODE,
      SAMPLE_PRELOAD,
      IC_RESET,
      ADDR_AXI_REGISTER,
      DATA_AXI_REGISTER,
      MGMT_AXI_REGISTER,
      EXTEST
   } ir_decoding_t;

   typedef struct packed {
      logic [2:0] size;
      logic       write;
   } s_axi_jtag_mgmt_t;

   localparam int MGMT_WIDTH = $bits(s_axi_jtag_mgmt_t);

   typedef struct packed {
      logic [ADDR_AXI_WIDTH-1:0] addr;
      logic [DATA_AXI_WIDTH-1:0] data;
      s_axi_jtag_mgmt_t          mgmt;
   } s_axi_jtag_t;

endpackage

module unique0_dr
   import jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE_VAL   = 32'h0000_010F,
   parameter int          IC_RST_WIDTH = 4
) (
   input  logic                    tck,
   input  logic                    trst,
   input  logic                    tdi,
   output logic                    tdo,
   input  tap_ctrl_fsm_t           tap_state,
   input  ir_decoding_t            ir_dec,
   output logic [IC_RST_WIDTH-1:0] ic_rst,
   output s_axi_jtag_t             axi_info,
   output logic                    axi_update
);

   if (IC_RST_WIDTH < 1 || IC_RST_WIDTH > DR_MAX_WIDTH) begin : g_badIcRstWidth
      $error("unique0_dr: IC_RST_WIDTH must be between 1 and DR_MAX_WIDTH");
   end

   logic                    bypass_q, bypass_d;
   logic [31:0]             idcode_q, idcode_d;
   logic [DR_MAX_WIDTH-1:0] sr_q, sr_d;
   logic [IC_RST_WIDTH-1:0] ic_rst_q, ic_rst_d;
   s_axi_jtag_t             axi_q, axi_d;
   logic                    axi_update_q, axi_update_d;

   // Only bit 0 of each register ever reaches TDO, so only that bit is shadowed.
   logic bypass_sh_q, idcode_sh_q, sr_sh_q;

   function automatic logic [DR_MAX_WIDTH-1:0] shiftWindow(
      input logic [DR_MAX_WIDTH-1:0] sr,
      input logic                    din,
      input int                      w
   );
      logic [DR_MAX_WIDTH-1:0] shr;
      logic [DR_MAX_WIDTH-1:0] res;
      shr = sr >> 1;
      res = sr;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < w - 1) begin
            res[i] = shr[i];
         end else if (i == w - 1) begin
            res[i] = din;
         end
      end
      return res;
   endfunction

   function automatic logic [DR_MAX_WIDTH-1:0] loadWindow(
      input logic [DR_MAX_WIDTH-1:0] sr,
      input logic [DR_MAX_WIDTH-1:0] val,
      input int                      w
   );
      logic [DR_MAX_WIDTH-1:0] res;
      res = sr;
      for (int i = 0; i < DR_MAX_WIDTH; i++) begin
         if (i < w) begin
            res[i] = val[i];
         end
      end
      return res;
   endfunction

   always_comb begin
      bypass_d     = bypass_q;
      idcode_d     = idcode_q;
      sr_d         = sr_q;
      ic_rst_d     = ic_rst_q;
      axi_d        = axi_q;
      axi_update_d = 1'b0;
      case (ir_dec)
         BYPASS: begin
            if (tap_state == CAPTURE_DR) begin
               bypass_d = 1'b0;
            end else if (tap_state == SHIFT_DR) begin
               bypass_d = tdi;
            end
         end
         IDCODE: begin
            if (tap_state == CAPTURE_DR) begin
               idcode_d = IDCODE_VAL;
            end else if (tap_state == SHIFT_DR) begin
               idcode_d = {tdi, idcode_q[31:1]};
            end
         end
         SAMPLE_PRELOAD: begin
            if (tap_state == CAPTURE_DR) begin
               sr_d = '0;
            end else if (tap_state == SHIFT_DR) begin
               sr_d = {tdi, sr_q[DR_MAX_WIDTH-1:1]};
            end
         end
         IC_RESET: begin
            if (tap_state == CAPTURE_DR) begin
               sr_d = loadWindow(sr_q, DR_MAX_WIDTH'(ic_rst_q), IC_RST_WIDTH);
            end else if (tap_state == SHIFT_DR) begin
               sr_d = shiftWindow(sr_q, tdi, IC_RST_WIDTH);
            end else if (tap_state == UPDATE_DR) begin
               ic_rst_d = sr_q[IC_RST_WIDTH-1:0];
            end
         end
         ADDR_AXI_REGISTER: begin
            if (tap_state == CAPTURE_DR) begin
               sr_d = loadWindow(sr_q, DR_MAX_WIDTH'(axi_q.addr), ADDR_AXI_WIDTH);
            end else if (tap_state == SHIFT_DR) begin
               sr_d = shiftWindow(sr_q, tdi, ADDR_AXI_WIDTH);
            end else if (tap_state == UPDATE_DR) begin
               axi_d.addr = sr_q[ADDR_AXI_WIDTH-1:0];
            end
         end
         DATA_AXI_REGISTER: begin
            if (tap_state == CAPTURE_DR) begin
               sr_d = loadWindow(sr_q, DR_MAX_WIDTH'(axi_q.data), DATA_AXI_WIDTH);
            end else if (tap_state == SHIFT_DR) begin
               sr_d = shiftWindow(sr_q, tdi, DATA_AXI_WIDTH);
            end else if (tap_state == UPDATE_DR) begin
               axi_d.data = sr_q[DATA_AXI_WIDTH-1:0];
            end
         end
         MGMT_AXI_REGISTER: begin
            // A management update is what launches the AXI request, hence the strobe.
            if (tap_state == CAPTURE_DR) begin
               sr_d = loadWindow(sr_q, DR_MAX_WIDTH'(axi_q.mgmt), MGMT_WIDTH);
            end else if (tap_state == SHIFT_DR) begin
               sr_d = shiftWindow(sr_q, tdi, MGMT_WIDTH);
            end else if (tap_state == UPDATE_DR) begin
               axi_d.mgmt   = s_axi_jtag_mgmt_t'(sr_q[MGMT_WIDTH-1:0]);
               axi_update_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         bypass_q     <= 1'b0;
         idcode_q     <= '0;
         sr_q         <= '0;
         ic_rst_q     <= '0;
         axi_q        <= '0;
         axi_update_q <= 1'b0;
      end else begin
         bypass_q     <= bypass_d;
         idcode_q     <= idcode_d;
         sr_q         <= sr_d;
         ic_rst_q     <= ic_rst_d;
         axi_q        <= axi_d;
         axi_update_q <= axi_update_d;
      end
   end

   always_ff @(negedge tck or posedge trst) begin
      if (trst) begin
         bypass_sh_q <= 1'b0;
         idcode_sh_q <= 1'b0;
         sr_sh_q     <= 1'b0;
      end else begin
         bypass_sh_q <= bypass_q;
         idcode_sh_q <= idcode_q[0];
         sr_sh_q     <= sr_q[0];
      end
   end

   always_comb begin
      tdo = 1'b0;
      if (tap_state == SHIFT_DR) begin
         case (ir_dec)
            BYPASS:            tdo = bypass_sh_q;
            IDCODE:            tdo = idcode_sh_q;
            SAMPLE_PRELOAD,
            IC_RESET,
            ADDR_AXI_REGISTER,
            DATA_AXI_REGISTER,
            MGMT_AXI_REGISTER: tdo = sr_sh_q;
            default:           tdo = 1'b0;
         endcase
      end
   end

   assign ic_rst     = ic_rst_q;
   assign axi_info   = axi_q;
   assign axi_update = axi_update_q;

endmodule

// File: tb/tb_unique0_dr.sv
// Directed bench for unique0_dr: drives TAP states/instructions cycle by cycle
// and compares TDO streams and register outputs against hand-computed values.

module tb_unique0_dr;
   import jtag_pkg::*;

   logic          tck = 1'b0;
   logic          trst;
   logic          tdi;
   logic          tdo;
   tap_ctrl_fsm_t tapState;
   ir_decoding_t  irDec;
   logic [3:0]    icRst;
   s_axi_jtag_t   axiInfo;
   logic          axiUpdate;

   int checks = 0;
   int errors = 0;

   logic        tdoBit;
   logic [31:0] readBack;

   unique0_dr dut (
      .tck        (tck),
      .trst       (trst),
      .tdi        (tdi),
      .tdo        (tdo),
      .tap_state  (tapState),
      .ir_dec     (irDec),
      .ic_rst     (icRst),
      .axi_info   (axiInfo),
      .axi_update (axiUpdate)
   );

   always #5 tck = ~tck;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One TAP cycle: inputs held for a full period, TDO sampled after the falling edge.
   task automatic applyStimulus(input tap_ctrl_fsm_t st, input ir_decoding_t ir, input logic din,
                                output logic tdoSeen);
      tapState = st;
      irDec    = ir;
      tdi      = din;
      @(negedge tck);
      #1 tdoSeen = tdo;
      @(posedge tck);
      #1;
   endtask

   task automatic shiftDr(input ir_decoding_t ir, input logic [31:0] din, input int n,
                          output logic [31:0] dout);
      logic b;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         applyStimulus(SHIFT_DR, ir, din[i], b);
         dout[i] = b;
      end
   endtask

   initial begin
      trst     = 1'b1;
      tapState = TEST_LOGIC_RESET;
      irDec    = BYPASS;
      tdi      = 1'b0;
      #12;
      checkOutput("reset_tdo", 32'(tdo), 32'h0);
      checkOutput("reset_ic_rst", 32'(icRst), 32'h0);
      checkOutput("reset_axi_addr", axiInfo.addr, 32'h0);
      checkOutput("reset_axi_update", 32'(axiUpdate), 32'h0);
      @(posedge tck);
      #2 trst = 1'b0;
      applyStimulus(RUN_TEST_IDLE, BYPASS, 1'b0, tdoBit);

      applyStimulus(CAPTURE_DR, IDCODE, 1'b0, tdoBit);
      shiftDr(IDCODE, 32'h0, 32, readBack);
      checkOutput("idcode_stream", readBack, 32'h0000_010F);

      // tdi 1,0,1,1 comes back delayed by one cycle behind the captured 0.
      applyStimulus(CAPTURE_DR, BYPASS, 1'b0, tdoBit);
      shiftDr(BYPASS, 32'b1101, 4, readBack);
      checkOutput("bypass_stream", readBack, 32'b1010);

      applyStimulus(CAPTURE_DR, IC_RESET, 1'b0, tdoBit);
      shiftDr(IC_RESET, 32'hA, 4, readBack);
      checkOutput("ic_rst_capture_old", readBack, 32'h0);
      applyStimulus(UPDATE_DR, IC_RESET, 1'b0, tdoBit);
      checkOutput("ic_rst_update", 32'(icRst), 32'hA);
      applyStimulus(CAPTURE_DR, IC_RESET, 1'b0, tdoBit);
      shiftDr(IC_RESET, 32'h0, 4, readBack);
      checkOutput("ic_rst_readback", readBack, 32'hA);

      applyStimulus(CAPTURE_DR, EXTEST, 1'b0, tdoBit);
      shiftDr(EXTEST, 32'hF, 4, readBack);
      checkOutput("unlisted_tdo", readBack, 32'h0);
      applyStimulus(UPDATE_DR, EXTEST, 1'b0, tdoBit);
      checkOutput("unlisted_hold_ic_rst", 32'(icRst), 32'hA);

      applyStimulus(CAPTURE_DR, ADDR_AXI_REGISTER, 1'b0, tdoBit);
      shiftDr(ADDR_AXI_REGISTER, 32'hDEAD_BEEF, 32, readBack);
      applyStimulus(UPDATE_DR, ADDR_AXI_REGISTER, 1'b0, tdoBit);
      checkOutput("axi_addr", axiInfo.addr, 32'hDEAD_BEEF);
      checkOutput("addr_no_update", 32'(axiUpdate), 32'h0);

      applyStimulus(CAPTURE_DR, DATA_AXI_REGISTER, 1'b0, tdoBit);
      shiftDr(DATA_AXI_REGISTER, 32'h1234_5678, 32, readBack);
      applyStimulus(UPDATE_DR, DATA_AXI_REGISTER, 1'b0, tdoBit);
      checkOutput("axi_data", axiInfo.data, 32'h1234_5678);
      checkOutput("axi_addr_kept", axiInfo.addr, 32'hDEAD_BEEF);
      checkOutput("data_no_update", 32'(axiUpdate), 32'h0);

      applyStimulus(CAPTURE_DR, MGMT_AXI_REGISTER, 1'b0, tdoBit);
      shiftDr(MGMT_AXI_REGISTER, 32'hB, 4, readBack);
      applyStimulus(UPDATE_DR, MGMT_AXI_REGISTER, 1'b0, tdoBit);
      checkOutput("axi_mgmt", 32'(axiInfo.mgmt), 32'hB);
      checkOutput("axi_update_pulse", 32'(axiUpdate), 32'h1);
      applyStimulus(RUN_TEST_IDLE, MGMT_AXI_REGISTER, 1'b0, tdoBit);
      checkOutput("axi_update_drop", 32'(axiUpdate), 32'h0);
      applyStimulus(CAPTURE_DR, MGMT_AXI_REGISTER, 1'b0, tdoBit);
      shiftDr(MGMT_AXI_REGISTER, 32'h0, 4, readBack);
      checkOutput("mgmt_readback", readBack, 32'hB);

      // Reset lands between clock edges while ADDR is mid-shift.
      applyStimulus(CAPTURE_DR, ADDR_AXI_REGISTER, 1'b0, tdoBit);
      shiftDr(ADDR_AXI_REGISTER, 32'h0, 5, readBack);
      checkOutput("addr_partial_stream", readBack, 32'h0F);
      #1 trst = 1'b1;
      #1;
      checkOutput("midreset_tdo", 32'(tdo), 32'h0);
      checkOutput("midreset_ic_rst", 32'(icRst), 32'h0);
      checkOutput("midreset_axi_addr", axiInfo.addr, 32'h0);
      checkOutput("midreset_axi_data", axiInfo.data, 32'h0);
      checkOutput("midreset_axi_mgmt", 32'(axiInfo.mgmt), 32'h0);
      checkOutput("midreset_axi_update", 32'(axiUpdate), 32'h0);
      @(posedge tck);
      #2 trst = 1'b0;
      applyStimulus(CAPTURE_DR, IDCODE, 1'b0, tdoBit);
      shiftDr(IDCODE, 32'h0, 32, readBack);
      checkOutput("idcode_after_reset", readBack, 32'h0000_010F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
